// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_BURST,
    FILL_REQ,
    FILL_BURST,
    REPLAY
  } mem_state_e;

  localparam int unsigned PAGE_W_DFLT = 8;
  localparam int unsigned PAGE_WORDS  = 2**PAGE_W_DFLT;

  localparam logic SD_RD = 1'b0;
  localparam logic SD_WR = 1'b1;

endpackage

// File: rtl/mem_stage_ctrl_dmem.sv
// Single-port synchronous RAM holding the resident SDRAM page; read data is registered.
module dmem_bank #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: registers result channels to MEM/WB and serves loads/stores from a
// one-page dmem window, writing back and refilling the page over SDRAM on a miss.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned LS_W   = 8,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned PAGE_W = PAGE_W_DFLT
) (
  input  logic                     ref_clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  input  logic [NUM_CH*TAG_W-1:0]  ch_tag_in,
  input  logic [NUM_CH-1:0]        ch_vld_in,
  output logic [NUM_CH*DATA_W-1:0] ch_data_out,
  output logic [NUM_CH*TAG_W-1:0]  ch_tag_out,
  output logic [NUM_CH-1:0]        ch_vld_out,
  input  logic                     ls_vld,
  input  logic                     ls_r_nw,
  input  logic [ADDR_W-1:0]        ls_addr,
  input  logic [LS_W-1:0]          ls_wdata,
  input  logic [TAG_W-1:0]         ls_tag_in,
  output logic [LS_W-1:0]          wb_data,
  output logic [TAG_W-1:0]         ls_tag_out,
  output logic                     ls_vld_out,
  output logic                     stall,
  output logic                     sd_req,
  output logic                     sd_we,
  output logic [ADDR_W-1:0]        sd_addr,
  output logic [PAGE_W:0]          sd_len,
  input  logic                     sd_granted,
  input  logic                     sd_busy,
  input  logic [LS_W-1:0]          sd_rdata,
  input  logic                     sd_rvalid,
  output logic [LS_W-1:0]          sd_wdata,
  input  logic                     sd_wready
);

  localparam int unsigned PT_W   = ADDR_W - PAGE_W;
  localparam int unsigned LEN_W  = PAGE_W + 1;
  localparam int unsigned PAGE_N = 2**PAGE_W;

  mem_state_e        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PT_W-1:0]   page_tag_q, page_tag_d, miss_tag_q, miss_tag_d;
  logic              page_vld_q, page_vld_d, dirty_q, dirty_d;
  logic              sd_req_d, sd_we_d;
  logic [ADDR_W-1:0] sd_addr_d;
  logic [LEN_W-1:0]  sd_len_d;

  logic              ram_en, ram_we;
  logic [PAGE_W-1:0] ram_addr;
  logic [LS_W-1:0]   ram_wdata, ram_rdata;
  logic              rd_live_q;
  logic [LS_W-1:0]   wb_hold_q;

  logic [PT_W-1:0]   req_tag;
  logic [PAGE_W-1:0] req_off;
  logic              hit;

  assign req_tag = ls_addr[ADDR_W-1:PAGE_W];
  assign req_off = ls_addr[PAGE_W-1:0];
  assign hit     = ls_vld & page_vld_q & (req_tag == page_tag_q);
  assign stall   = (ls_vld & ~hit & (state_q == IDLE)) | (state_q != IDLE);
  assign cnt_inc = cnt_q + LEN_W'(1);

  // RAM output is live only after an unstalled cycle; bursts reuse the port, so hold the last load result
  assign wb_data  = rd_live_q ? ram_rdata : wb_hold_q;
  assign sd_wdata = (state_q == WB_BURST) ? ram_rdata : '0;

  dmem_bank #(.DEPTH(PAGE_N), .WIDTH(LS_W)) u_dmem (
    .clk   (ref_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, page bookkeeping, SDRAM request and dmem port arbitration
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_tag_d = page_tag_q;
    miss_tag_d = miss_tag_q;
    page_vld_d = page_vld_q;
    dirty_d    = dirty_q;
    sd_req_d   = sd_req;
    sd_we_d    = sd_we;
    sd_addr_d  = sd_addr;
    sd_len_d   = sd_len;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = req_off;
    ram_wdata  = ls_wdata;

    unique case (state_q)
      IDLE: begin
        if (ls_vld && !hit) begin
          miss_tag_d = req_tag;
          state_d    = (page_vld_q && dirty_q) ? WB_REQ : FILL_REQ;
        end else if (hit) begin
          ram_en = 1'b1;
          ram_we = ~ls_r_nw;
          if (!ls_r_nw) dirty_d = 1'b1;
        end
      end
      WB_REQ: begin
        // Prime word 0 so it is on sd_wdata from the first burst cycle
        ram_en   = 1'b1;
        ram_addr = '0;
        if (!sd_req) begin
          if (!sd_busy) begin
            sd_req_d  = 1'b1;
            sd_we_d   = SD_WR;
            sd_addr_d = {page_tag_q, {PAGE_W{1'b0}}};
            sd_len_d  = LEN_W'(PAGE_N);
          end
        end else if (sd_granted) begin
          sd_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = WB_BURST;
        end
      end
      WB_BURST: begin
        ram_en   = 1'b1;
        ram_addr = sd_wready ? cnt_inc[PAGE_W-1:0] : cnt_q[PAGE_W-1:0];
        if (sd_wready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LEN_W'(PAGE_N)) begin
            dirty_d = 1'b0;
            state_d = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        if (!sd_req) begin
          if (!sd_busy) begin
            sd_req_d  = 1'b1;
            sd_we_d   = SD_RD;
            sd_addr_d = {miss_tag_q, {PAGE_W{1'b0}}};
            sd_len_d  = LEN_W'(PAGE_N);
          end
        end else if (sd_granted) begin
          sd_req_d   = 1'b0;
          cnt_d      = '0;
          page_vld_d = 1'b0;
          state_d    = FILL_BURST;
        end
      end
      FILL_BURST: begin
        if (sd_rvalid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cnt_q[PAGE_W-1:0];
          ram_wdata = sd_rdata;
          cnt_d     = cnt_inc;
          if (cnt_inc == LEN_W'(PAGE_N)) begin
            page_tag_d = miss_tag_q;
            page_vld_d = 1'b1;
            dirty_d    = 1'b0;
            state_d    = REPLAY;
          end
        end
      end
      REPLAY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, page tracking and MEM/WB pipeline registers
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      page_tag_q  <= '0;
      miss_tag_q  <= '0;
      page_vld_q  <= 1'b0;
      dirty_q     <= 1'b0;
      sd_req      <= 1'b0;
      sd_we       <= 1'b0;
      sd_addr     <= '0;
      sd_len      <= '0;
      ch_data_out <= '0;
      ch_tag_out  <= '0;
      ch_vld_out  <= '0;
      ls_tag_out  <= '0;
      ls_vld_out  <= 1'b0;
      rd_live_q   <= 1'b0;
      wb_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      page_tag_q <= page_tag_d;
      miss_tag_q <= miss_tag_d;
      page_vld_q <= page_vld_d;
      dirty_q    <= dirty_d;
      sd_req     <= sd_req_d;
      sd_we      <= sd_we_d;
      sd_addr    <= sd_addr_d;
      sd_len     <= sd_len_d;
      if (!stall) begin
        ch_data_out <= ch_data_in;
        ch_tag_out  <= ch_tag_in;
        ch_vld_out  <= ch_vld_in;
        ls_tag_out  <= ls_tag_in;
        ls_vld_out  <= hit & ls_r_nw;
      end else begin
        ch_vld_out <= '0;
        ls_vld_out <= 1'b0;
      end
      rd_live_q <= ~stall;
      if (rd_live_q) wb_hold_q <= ram_rdata;
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Parametrised next-generation memory pipeline stage. Registers N execution-result channels through to MEM/WB and serves the load/store unit from a one-page on-chip data memory (dmem_bank) that windows SDRAM. A page miss stalls the pipeline. If the resident page is dirty, it is written back to SDRAM first; the new page is then filled over the SDRAM controller's request/grant handshake before the access completes.

Parameters:
NUM_CH, 3, number of pass-through result channels (ALU0, ALU1, MUL)
DATA_W, 16, pass-through result width
TAG_W, 5, destination-register tag width
LS_W, 8, load/store data width
ADDR_W, 25, SDRAM byte address width
PAGE_W, 8, log2 of page size in LS_W words; dmem depth = 2**PAGE_W

Ports:
ref_clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_data_in  in  NUM_CH*DATA_W  packed channel results, channel 0 in LSBs
ch_tag_in  in  NUM_CH*TAG_W  packed Rd tags
ch_vld_in  in  NUM_CH  channel valid
ch_data_out  out  NUM_CH*DATA_W  registered results
ch_tag_out  out  NUM_CH*TAG_W  registered tags
ch_vld_out  out  NUM_CH  registered valid
ls_vld  in  1  load/store request
ls_r_nw  in  1  1 = load, 0 = store
ls_addr  in  ADDR_W  byte address
ls_wdata  in  LS_W  store data
ls_tag_in  in  TAG_W  load Rd tag
wb_data  out  LS_W  load result
ls_tag_out  out  TAG_W  load tag, aligned with wb_data
ls_vld_out  out  1  load result valid
stall  out  1  freeze upstream stages
sd_req  out  1  burst request to SDRAM controller
sd_we  out  1  1 = write-back burst, 0 = fill burst
sd_addr  out  ADDR_W  page base address (low PAGE_W bits zero)
sd_len  out  PAGE_W+1  burst length in words
sd_granted  in  1  one-cycle grant pulse
sd_busy  in  1  SDRAM controller busy
sd_rdata  in  LS_W  fill data
sd_rvalid  in  1  fill word valid
sd_wdata  out  LS_W  write-back data
sd_wready  in  1  write-back word accepted

Behaviour:
- Reset state: all outputs 0, state IDLE, page_vld=0, dirty=0, counters 0. Reset mid-burst aborts the burst, drops sd_req, and invalidates the page (no partial data is kept).
- Page split: page_tag = ls_addr[ADDR_W-1:PAGE_W]; offset = ls_addr[PAGE_W-1:0].
- Hit: ls_vld & page_vld & tag match.
- stall is combinational: (ls_vld & ~hit & state==IDLE) | (state!=IDLE).
- Pass-through registers:
  - Load every cycle when stall=0; 1-cycle latency.
  - When stall=1, hold their values and force ch_vld_out=0 and ls_vld_out=0 (bubble).
- Hit load: dmem is read synchronously. wb_data, ls_tag_out and ls_vld_out=1 appear 1 cycle later, aligned with the channel outputs.
- Hit store: dmem is written at offset on the clock edge; dirty is set to 1. ls_vld_out=0.
- FSM states: IDLE, WB_REQ, WB_BURST, FILL_REQ, FILL_BURST, REPLAY.
  - IDLE: on a miss, go to WB_REQ if page_vld & dirty, else FILL_REQ. Latch the miss address.
  - WB_REQ: assert sd_req once sd_busy=0, with sd_we=1, sd_addr = old tag base, sd_len = 2**PAGE_W. Hold sd_req until sd_granted, then go to WB_BURST with cnt=0.
  - WB_BURST: sd_wdata = dmem[cnt], prefetched so data is valid in the cycle sd_wready is sampled. Increment cnt on sd_wready. After the last word, clear dirty and go to FILL_REQ.
  - FILL_REQ: same handshake with sd_we=0 and the new tag base. Go to FILL_BURST on grant.
  - FILL_BURST: each sd_rvalid writes sd_rdata into dmem[cnt], then cnt++. After the last word, set page_tag, page_vld=1, dirty=0, and go to REPLAY.
  - REPLAY: keep stall=1 for exactly one cycle, then return to IDLE. The held request then hits.
- Handshake boundary rules:
  - sd_granted outside a *_REQ state is ignored.
  - sd_rvalid outside FILL_BURST is ignored.
  - sd_wready outside WB_BURST is ignored.
  - Counter is PAGE_W+1 bits; the burst ends when cnt reaches 2**PAGE_W, with no wrap.
- Simultaneous events: a store hit and pass-through update in the same cycle both complete. ls_vld with sd_* activity while in IDLE: the SDRAM inputs are ignored.

Decomposition:
- Package mem_pkg: state enum mem_state_e, localparam PAGE_WORDS = 2**PAGE_W, SD_RD/SD_WR encodings for sd_we.
- Sub-module dmem_bank: single-port synchronous RAM, DEPTH/WIDTH parameters, registered read. Arbitration between the LS port and burst ports (FSM state select) stays in mem_stage_ctrl.

Test Plan:
- After reset, channels ch_data_in={16'h0003,16'h0002,16'h0001}, ch_vld_in=3'b111 -> same values on outputs 1 cycle later; stall=0.
- Cold load, PAGE_W=4, ls_addr=25'h000123 -> stall rises the same cycle; sd_req with sd_we=0, sd_addr=25'h000120, sd_len=16. Fill bytes 8'h10..8'h1F arrive on grant -> wb_data=8'h13, ls_vld_out=1, one cycle after REPLAY.
- Store hit at 25'h000125 with 8'hAA, then load at 25'h000125 -> wb_data=8'hAA; no sd_req.
- Dirty page, then load at 25'h000200 -> write-back burst first (sd_we=1, sd_addr=25'h000120, word 5 = 8'hAA), then fill at 25'h000200.
- sd_busy held high 10 cycles during FILL_REQ -> sd_req stays 0 until sd_busy drops; a stray sd_granted while in IDLE is ignored.
- rst asserted mid-FILL_BURST after 7 words -> next cycle sd_req=0, stall=0, page_vld=0; a reload of the same address misses again.
